sprite_motion_ctrl: RTL and testbench



---
 rtl/sprite_motion_pkg.sv | 26 ++
 rtl/motion_axis.sv | 130 +++++++++++++
 rtl/sprite_motion_ctrl.sv | 159 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_motion_pkg.sv
// Shared types and constants for the sprite motion engine.
// Frame sequencer states, edge-code bit positions and playfield defaults.
package sprite_motion_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_VEL_UPD,
    S_POS_UPD,
    S_LIMIT
  } state_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int PIX_W = 11;
  localparam int VEL_W = 8;

  localparam int DEF_X_MIN = 33;
  localparam int DEF_X_MAX = 517;
  localparam int DEF_Y_MIN = 33;
  localparam int DEF_Y_MAX = 414;

endpackage

// File: rtl/motion_axis.sv
// One axis of the motion engine: momentum, blocking, integration, clamp.
// Sequenced by phase enables from the top-level frame FSM.
module motion_axis
  import sprite_motion_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int INIT      = 280,
  parameter int ACCEL     = 8,
  parameter int FRICTION  = 4,
  parameter int MAX_SPEED = 40,
  parameter int LO        = 33,
  parameter int HI        = 517
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vel_upd_i,
  input  logic                    pos_upd_i,
  input  logic                    limit_i,
  input  logic                    key_pos_i,
  input  logic                    key_neg_i,
  input  logic                    blk_pos_i,
  input  logic                    blk_neg_i,
  input  logic                    freeze_i,
  input  logic                    tp_load_i,
  input  logic signed [PIX_W-1:0] tp_dest_i,
  output logic signed [PIX_W-1:0] pix_o,
  output logic signed [VEL_W-1:0] vel_o
);

  localparam int POS_W = PIX_W + FRAC_BITS + 1;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [VEL_W:0]   vwide_t;

  localparam pos_t INIT_F = pos_t'(INIT * (2 ** FRAC_BITS));
  localparam pos_t LO_F   = pos_t'(LO * (2 ** FRAC_BITS));
  localparam pos_t HI_F   = pos_t'(HI * (2 ** FRAC_BITS));

  localparam vwide_t ACC_W = vwide_t'(ACCEL);
  localparam vwide_t MAX_W = vwide_t'(MAX_SPEED);
  localparam vwide_t MIN_W = vwide_t'(-MAX_SPEED);
  localparam vel_t   FRIC  = vel_t'(FRICTION);
  localparam vel_t   NFRIC = vel_t'(-FRICTION);
  localparam vel_t   VZ    = '0;

  pos_t   pos_q;
  pos_t   pos_nx;
  pos_t   pos_tp;
  pos_t   pos_cl;
  vel_t   v_q;
  vel_t   v_acc;
  vel_t   v_blk;
  vel_t   v_cl;
  vel_t   vout_q;
  vwide_t v_sum;
  logic signed [PIX_W-1:0] pix_q;

  always_comb begin
    v_sum = '0;
    v_acc = v_q;
    if (key_pos_i ^ key_neg_i) begin
      v_sum = key_pos_i ? vwide_t'(v_q) + ACC_W
                        : vwide_t'(v_q) - ACC_W;
      if (v_sum > MAX_W)
        v_acc = vel_t'(MAX_W);
      else if (v_sum < MIN_W)
        v_acc = vel_t'(MIN_W);
      else
        v_acc = vel_t'(v_sum);
    end else if (v_q > FRIC) begin
      v_acc = v_q - FRIC;
    end else if (v_q < NFRIC) begin
      v_acc = v_q + FRIC;
    end else begin
      v_acc = VZ;
    end
    v_blk = v_acc;
    if ((blk_pos_i && v_acc > VZ) ||
        (blk_neg_i && v_acc < VZ) ||
        freeze_i)
      v_blk = VZ;
  end

  assign pos_nx = pos_q + pos_t'(v_q);
  assign pos_tp = pos_t'(tp_dest_i) <<< FRAC_BITS;

  // Velocity pointing back into the field survives a clamp.
  always_comb begin
    pos_cl = pos_q;
    v_cl   = v_q;
    if (pos_q < LO_F) begin
      pos_cl = LO_F;
      if (v_q < VZ) v_cl = VZ;
    end else if (pos_q > HI_F) begin
      pos_cl = HI_F;
      if (v_q > VZ) v_cl = VZ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= INIT_F;
      v_q    <= VZ;
      pix_q  <= PIX_W'(INIT);
      vout_q <= VZ;
    end else begin
      if (vel_upd_i)
        v_q <= v_blk;
      if (pos_upd_i) begin
        if (tp_load_i) begin
          pos_q <= pos_tp;
          v_q   <= VZ;
        end else begin
          pos_q <= pos_nx;
        end
      end
      if (limit_i) begin
        pos_q  <= pos_cl;
        v_q    <= v_cl;
        pix_q  <= pos_cl[FRAC_BITS +: PIX_W];
        vout_q <= v_cl;
      end
    end
  end

  assign pix_o = pix_q;
  assign vel_o = vout_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion engine: latches collision/teleport events
// between frames, then runs a 3-phase velocity/position/limit update.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int FRAC_BITS   = 6,
  parameter int INIT_X      = 280,
  parameter int INIT_Y      = 185,
  parameter int ACCEL       = 8,
  parameter int FRICTION    = 4,
  parameter int MAX_SPEED_X = 40,
  parameter int MAX_SPEED_Y = 20,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MIN       = DEF_Y_MIN,
  parameter int Y_MAX       = DEF_Y_MAX
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    key_up,
  input  logic                    key_down,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    collision,
  input  logic [3:0]              HitEdgeCode,
  input  logic                    teleport_req,
  input  logic signed [PIX_W-1:0] teleport_x,
  input  logic signed [PIX_W-1:0] teleport_y,
  input  logic                    freeze,
  output logic signed [PIX_W-1:0] topLeftX,
  output logic signed [PIX_W-1:0] topLeftY,
  output logic signed [VEL_W-1:0] vel_x,
  output logic signed [VEL_W-1:0] vel_y,
  output logic                    moving,
  output logic                    frame_done
);

  state_t                  state_q;
  logic [3:0]              col_q;
  logic [3:0]              col_nxt_q;
  logic                    tp_pend_q;
  logic signed [PIX_W-1:0] tp_x_q;
  logic signed [PIX_W-1:0] tp_y_q;
  logic                    frame_done_q;
  logic [3:0]              hit;
  logic                    vel_upd;
  logic                    pos_upd;
  logic                    limit;
  logic                    tp_load;

  assign hit = collision ? HitEdgeCode : 4'b0000;

  // A hit on the SOF cycle is parked in col_nxt_q for the next frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      col_nxt_q    <= '0;
      tp_pend_q    <= 1'b0;
      tp_x_q       <= '0;
      tp_y_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (startOfFrame) state_q <= S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          if (teleport_req) begin
            tp_pend_q <= 1'b1;
            tp_x_q    <= teleport_x;
            tp_y_q    <= teleport_y;
          end
          if (startOfFrame) begin
            col_nxt_q <= col_nxt_q | hit;
            state_q   <= S_VEL_UPD;
          end else begin
            col_q <= col_q | hit;
          end
        end
        S_VEL_UPD: begin
          col_q     <= col_nxt_q;
          col_nxt_q <= '0;
          state_q   <= S_POS_UPD;
        end
        S_POS_UPD: begin
          tp_pend_q <= 1'b0;
          state_q   <= S_LIMIT;
        end
        S_LIMIT: begin
          frame_done_q <= 1'b1;
          state_q      <= S_WAIT_SOF;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vel_upd = (state_q == S_VEL_UPD);
  assign pos_upd = (state_q == S_POS_UPD);
  assign limit   = (state_q == S_LIMIT);
  assign tp_load = tp_pend_q & ~freeze;

  motion_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT      (INIT_X),
    .ACCEL     (ACCEL),
    .FRICTION  (FRICTION),
    .MAX_SPEED (MAX_SPEED_X),
    .LO        (X_MIN),
    .HI        (X_MAX)
  ) u_axis_x (
    .clk       (clk),
    .rst_n     (resetN),
    .vel_upd_i (vel_upd),
    .pos_upd_i (pos_upd),
    .limit_i   (limit),
    .key_pos_i (key_right),
    .key_neg_i (key_left),
    .blk_pos_i (col_q[EDGE_RIGHT]),
    .blk_neg_i (col_q[EDGE_LEFT]),
    .freeze_i  (freeze),
    .tp_load_i (tp_load),
    .tp_dest_i (tp_x_q),
    .pix_o     (topLeftX),
    .vel_o     (vel_x)
  );

  motion_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT      (INIT_Y),
    .ACCEL     (ACCEL),
    .FRICTION  (FRICTION),
    .MAX_SPEED (MAX_SPEED_Y),
    .LO        (Y_MIN),
    .HI        (Y_MAX)
  ) u_axis_y (
    .clk       (clk),
    .rst_n     (resetN),
    .vel_upd_i (vel_upd),
    .pos_upd_i (pos_upd),
    .limit_i   (limit),
    .key_pos_i (key_down),
    .key_neg_i (key_up),
    .blk_pos_i (col_q[EDGE_BOTTOM]),
    .blk_neg_i (col_q[EDGE_TOP]),
    .freeze_i  (freeze),
    .tp_load_i (tp_load),
    .tp_dest_i (tp_y_q),
    .pix_o     (topLeftY),
    .vel_o     (vel_y)
  );

  assign moving     = (vel_x != '0) | (vel_y != '0);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with a per-frame scoreboard.
// Expected frame results are queued at SOF and checked at frame_done.
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic key_up, key_down, key_left, key_right;
  logic collision;
  logic [3:0] HitEdgeCode;
  logic teleport_req;
  logic signed [10:0] teleport_x, teleport_y;
  logic freeze;
  logic signed [10:0] topLeftX, topLeftY;
  logic signed [7:0] vel_x, vel_y;
  logic moving, frame_done;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int mv;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  int r6x[6]   = '{280, 280, 280, 281, 281, 282};
  int r6v[6]   = '{8, 16, 24, 32, 40, 40};
  int f10x[10] = '{283, 283, 284, 284, 284, 284, 285, 285, 285, 285};
  int c14x[14] = '{510, 510, 510, 511, 511, 512, 513,
                   513, 514, 515, 515, 516, 516, 517};
  int c14v[14] = '{8, 16, 24, 32, 40, 40, 40,
                   40, 40, 40, 40, 40, 40, 0};

  sprite_motion_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .teleport_req (teleport_req),
    .teleport_x   (teleport_x),
    .teleport_y   (teleport_y),
    .freeze       (freeze),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .vel_x        (vel_x),
    .vel_y        (vel_y),
    .moving       (moving),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic r, input logic l,
                       input logic u, input logic d,
                       input int ex, input int ey,
                       input int evx, input int evy, input int emv,
                       input logic [3:0] sof_hit);
    exp_t e;
    exp_t got_e;
    logic got;
    key_right = r;
    key_left  = l;
    key_up    = u;
    key_down  = d;
    e.x = ex; e.y = ey; e.vx = evx; e.vy = evy; e.mv = emv;
    @(negedge clk);
    startOfFrame = 1'b1;
    sb.push_back(e);
    if (sof_hit != 4'b0000) begin
      collision   = 1'b1;
      HitEdgeCode = sof_hit;
    end
    @(negedge clk);
    startOfFrame = 1'b0;
    collision    = 1'b0;
    HitEdgeCode  = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      if (frame_done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("frame_done_seen", int'(got), 1);
    got_e = sb.pop_front();
    if (got) begin
      chk("topLeftX", int'(topLeftX), got_e.x);
      chk("topLeftY", int'(topLeftY), got_e.y);
      chk("vel_x", int'(vel_x), got_e.vx);
      chk("vel_y", int'(vel_y), got_e.vy);
      chk("moving", int'(moving), got_e.mv);
      @(negedge clk);
      chk("frame_done_pulse", int'(frame_done), 0);
    end
  endtask

  task automatic pulse_col(input logic [3:0] code);
    @(negedge clk);
    collision   = 1'b1;
    HitEdgeCode = code;
    @(negedge clk);
    collision   = 1'b0;
    HitEdgeCode = 4'b0000;
  endtask

  task automatic pulse_tp(input int tx, input int ty);
    @(negedge clk);
    teleport_req = 1'b1;
    teleport_x   = 11'(tx);
    teleport_y   = 11'(ty);
    @(negedge clk);
    teleport_req = 1'b0;
  endtask

  task automatic quiet_check(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | frame_done;
    end
    chk(tag, int'(seen), 0);
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0000;
    collision = 1'b0;
    HitEdgeCode = 4'b0000;
    teleport_req = 1'b0;
    teleport_x = '0;
    teleport_y = '0;
    freeze = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_x", int'(topLeftX), 280);
    chk("rst_y", int'(topLeftY), 185);
    chk("rst_vx", int'(vel_x), 0);
    chk("rst_vy", int'(vel_y), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    resetN = 1'b1;

    // First SOF only leaves IDLE; nothing is integrated.
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    quiet_check("idle_sof_no_frame");
    chk("idle_x", int'(topLeftX), 280);

    for (int i = 0; i < 6; i++)
      frame(1, 0, 0, 0, r6x[i], 185, r6v[i], 0, 1, 4'b0000);

    for (int i = 0; i < 10; i++)
      frame(0, 0, 0, 0, f10x[i], 185, 36 - 4 * i, 0,
            (i == 9) ? 0 : 1, 4'b0000);

    frame(1, 1, 0, 0, 285, 185, 0, 0, 0, 4'b0000);

    pulse_col(4'b0100);
    frame(0, 0, 1, 0, 285, 185, 0, 0, 0, 4'b0000);
    frame(0, 0, 1, 0, 285, 184, 0, -8, 1, 4'b0000);
    frame(0, 0, 0, 0, 285, 184, 0, -4, 1, 4'b0000);
    frame(0, 0, 0, 0, 285, 184, 0, 0, 0, 4'b0000);

    frame(0, 0, 0, 1, 285, 184, 0, 8, 1, 4'b0001);
    frame(0, 0, 0, 1, 285, 184, 0, 0, 0, 4'b0000);
    frame(0, 0, 0, 1, 285, 185, 0, 8, 1, 4'b0000);
    frame(0, 0, 0, 0, 285, 185, 0, 4, 1, 4'b0000);
    frame(0, 0, 0, 0, 285, 185, 0, 0, 0, 4'b0000);

    pulse_tp(480, 32);
    frame(0, 0, 0, 0, 480, 33, 0, 0, 0, 4'b0000);

    freeze = 1'b1;
    pulse_tp(100, 100);
    frame(1, 0, 0, 0, 480, 33, 0, 0, 0, 4'b0000);
    freeze = 1'b0;
    frame(0, 0, 0, 0, 480, 33, 0, 0, 0, 4'b0000);

    pulse_tp(510, 200);
    frame(0, 0, 0, 0, 510, 200, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 14; i++)
      frame(1, 0, 0, 0, c14x[i], 200, c14v[i], 0,
            (c14v[i] != 0) ? 1 : 0, 4'b0000);
    frame(1, 0, 0, 0, 517, 200, 0, 0, 0, 4'b0000);
    frame(0, 1, 0, 0, 516, 200, -8, 0, 1, 4'b0000);

    // Reset lands while the engine sits in POS_UPD.
    {key_up, key_down, key_left, key_right} = 4'b0000;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_x", int'(topLeftX), 280);
    chk("midrst_y", int'(topLeftY), 185);
    chk("midrst_vx", int'(vel_x), 0);
    chk("midrst_moving", int'(moving), 0);
    @(negedge clk);
    resetN = 1'b1;
    quiet_check("midrst_no_frame");

    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    frame(0, 0, 0, 0, 280, 185, 0, 0, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
